// File: rtl/muldiv_sched_pkg.sv
// Shared types and constants for the mul_div round-robin scheduler.
package muldiv_sched_pkg;

  localparam int FP_W     = 32;
  localparam int TAG_ID_W = 3;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef struct packed {
    logic io;
    logic dz;
    logic of;
    logic uf;
    logic i;
  } flags_t;

  // Widest tag; a block may narrow the id to its own requester count.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/muldiv_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searching upward from ptr+1.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  always_comb begin
    logic           found;
    int             idx;
    logic [IDW-1:0] cand;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx  = (int'(ptr) + k) % NREQ;
      cand = IDW'(idx);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_id    = cand;
      end
    end
  end

endmodule

// File: rtl/muldiv_rr_sched.sv
// Shares one fixed-latency mul_div unit among NREQ requesters with round-robin issue.
// Optional grant/busy counters are built when MULDIV_SCHED_PERF_EN is defined.
module muldiv_rr_sched
  import muldiv_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              run,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]   req_sel,
  output logic              md_en,
  output logic [31:0]       md_a,
  output logic [31:0]       md_b,
  output logic              md_sel,
  input  logic [31:0]       md_r,
  input  logic [4:0]        md_flags,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_r,
  output logic [4:0]        rsp_flags,
  output logic              idle
`ifdef MULDIV_SCHED_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [NREQ*16-1:0] perf_grants,
  output logic [15:0]       perf_busy
`endif
);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } stage_tag_t;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            grant;
  logic            tags_busy;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            md_en_q, md_en_d;
  logic [FP_W-1:0] md_a_q, md_a_d;
  logic [FP_W-1:0] md_b_q, md_b_d;
  logic            md_sel_q, md_sel_d;

  stage_tag_t [LAT-1:0] tag_q, tag_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [FP_W-1:0] rsp_r_q, rsp_r_d;
  flags_t          rsp_flags_q, rsp_flags_d;

  // Gating with arst keeps req_ready low while reset is asserted.
  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req_valid),
    .en     (run & arst),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign grant     = |gnt;
  assign req_ready = gnt;

  always_comb begin
    ptr_d    = ptr_q;
    md_en_d  = grant;
    md_a_d   = md_a_q;
    md_b_d   = md_b_q;
    md_sel_d = md_sel_q;
    if (grant) begin
      ptr_d    = gnt_id;
      md_a_d   = req_a[int'(gnt_id)*FP_W +: FP_W];
      md_b_d   = req_b[int'(gnt_id)*FP_W +: FP_W];
      md_sel_d = req_sel[gnt_id];
    end
  end

  always_comb begin
    tag_d[0].valid = grant;
    tag_d[0].id    = gnt_id;
    for (int s = 1; s < LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      tags_busy = tags_busy | tag_q[s].valid;
    end
  end

  // The last tag stage lines up with md_r, so the response captures both together.
  always_comb begin
    rsp_valid_d = tag_q[LAT-1].valid;
    rsp_id_d    = rsp_id_q;
    rsp_r_d     = rsp_r_q;
    rsp_flags_d = rsp_flags_q;
    if (tag_q[LAT-1].valid) begin
      rsp_id_d    = tag_q[LAT-1].id;
      rsp_r_d     = md_r;
      rsp_flags_d = flags_t'(md_flags);
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      ptr_q       <= IDW'(NREQ - 1);
      md_en_q     <= 1'b0;
      md_a_q      <= '0;
      md_b_q      <= '0;
      md_sel_q    <= OP_MUL;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_r_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      md_en_q     <= md_en_d;
      md_a_q      <= md_a_d;
      md_b_q      <= md_b_d;
      md_sel_q    <= md_sel_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_r_q     <= rsp_r_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign md_en     = md_en_q;
  assign md_a      = md_a_q;
  assign md_b      = md_b_q;
  assign md_sel    = md_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_flags = rsp_flags_q;
  assign idle      = !tags_busy && !rsp_valid_q && !grant;

`ifdef MULDIV_SCHED_PERF_EN
  logic [NREQ-1:0][15:0] perf_grants_q, perf_grants_d;
  logic [15:0]           perf_busy_q, perf_busy_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    perf_grants_d = perf_grants_q;
    perf_busy_d   = perf_busy_q;
    if (perf_clr) begin
      perf_grants_d = '0;
      perf_busy_d   = '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) perf_grants_d[i] = sat_inc16(perf_grants_q[i]);
      end
      if (!idle) perf_busy_d = sat_inc16(perf_busy_q);
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      perf_grants_q <= '0;
      perf_busy_q   <= '0;
    end else begin
      perf_grants_q <= perf_grants_d;
      perf_busy_q   <= perf_busy_d;
    end
  end

  assign perf_grants = perf_grants_q;
  assign perf_busy   = perf_busy_q;
`endif

endmodule

// File: tb/tb_muldiv_rr_sched.sv
// Bench for muldiv_rr_sched with a behavioural LAT=2 mul_div stand-in and response scoreboard.
module tb_muldiv_rr_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              arst = 1'b0;
  logic              run = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a = '0;
  logic [NREQ*32-1:0] req_b = '0;
  logic [NREQ-1:0]   req_sel = '0;
  logic              md_en;
  logic [31:0]       md_a, md_b;
  logic              md_sel;
  logic [31:0]       md_r = '0;
  logic [4:0]        md_flags = '0;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_r;
  logic [4:0]        rsp_flags;
  logic              idle;
`ifdef MULDIV_SCHED_PERF_EN
  logic              perf_clr = 1'b0;
  logic [NREQ*16-1:0] perf_grants;
  logic [15:0]       perf_busy;
`endif

  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    r;
    logic [4:0]     flags;
  } exp_t;
  exp_t exp_q[$];

  muldiv_rr_sched #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk       (clk),
    .arst      (arst),
    .run       (run),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .md_en     (md_en),
    .md_a      (md_a),
    .md_b      (md_b),
    .md_sel    (md_sel),
    .md_r      (md_r),
    .md_flags  (md_flags),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_r     (rsp_r),
    .rsp_flags (rsp_flags),
    .idle      (idle)
`ifdef MULDIV_SCHED_PERF_EN
    ,
    .perf_clr    (perf_clr),
    .perf_grants (perf_grants),
    .perf_busy   (perf_busy)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for mul_div: known IEEE cases exactly, otherwise a deterministic scramble.
  function automatic logic [36:0] md_model(input logic [31:0] a, input logic [31:0] b, input logic sel);
    logic [31:0] r;
    if (!sel && a == 32'h4000_0000 && b == 32'h4040_0000) return {32'h40C0_0000, 5'b00000};
    if (sel && b[30:0] == 31'd0 && a[30:0] != 31'd0 && a[30:23] != 8'hFF)
      return {a[31] ^ b[31], 31'h7F80_0000, 5'b01000};
    r = a ^ {b[15:0], b[31:16]} ^ (sel ? 32'h5A5A_0F0F : 32'h0);
    return {r, r[4:0] ^ {4'b0000, sel}};
  endfunction

  // LAT=2: operands presented in cycle t give a result visible in cycle t+1.
  always @(posedge clk) begin
    if (md_en) {md_r, md_flags} <= md_model(md_a, md_b, md_sel);
  end

  always @(negedge clk) begin
    logic [36:0] m;
    exp_t        e;
    if (arst) begin
      if (req_ready != '0) begin
        checks++;
        if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
          errors++;
          $display("FAIL ready_onehot ready=%b valid=%b required one-hot subset", req_ready, req_valid);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          m = md_model(req_a[i*32 +: 32], req_b[i*32 +: 32], req_sel[i]);
          e.id = IDW'(i);
          e.r = m[36:5];
          e.flags = m[4:0];
          exp_q.push_back(e);
        end
      end
    end
    if (rsp_valid) begin
      rsp_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got id=%0d r=%h required no response", rsp_id, rsp_r);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_id, rsp_r, rsp_flags} !== {e.id, e.r, e.flags}) begin
          errors++;
          $display("FAIL rsp_data got id=%0d r=%h f=%b required id=%0d r=%h f=%b",
                   rsp_id, rsp_r, rsp_flags, e.id, e.r, e.flags);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*32 +: 32] = $urandom;
      req_b[i*32 +: 32] = $urandom;
      req_sel[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    arst = 1'b0;
    req_valid = '0;
    run = 1'b1;
    step();
    step();
    exp_q.delete();
    arst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    arst = 1'b0;
    step();
    checks++;
    if ({req_ready, md_en, md_a, md_b, md_sel, rsp_valid, rsp_id, rsp_r, rsp_flags, idle} !==
        {4'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values ready=%b en=%b a=%h b=%h rv=%b r=%h idle=%b required zeros idle=1",
               req_ready, md_en, md_a, md_b, rsp_valid, rsp_r, idle);
    end
    arst = 1'b1;
    step();
  endtask

  task automatic test_single();
    int cyc;
    req_a[32 +: 32] = 32'h4000_0000;
    req_b[32 +: 32] = 32'h4040_0000;
    req_sel[1] = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_grant got %b required 0010", req_ready);
    end
    step();
    req_valid = '0;
    cyc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (md_en !== 1'b1 || md_a !== 32'h4000_0000 || md_b !== 32'h4040_0000 || md_sel !== 1'b0) begin
          errors++;
          $display("FAIL single_issue got en=%b a=%h b=%h sel=%b required 1 40000000 40400000 0",
                   md_en, md_a, md_b, md_sel);
        end
      end
      if (rsp_valid) break;
    end
    checks++;
    if (cyc !== 3 || rsp_id !== 2'd1 || rsp_r !== 32'h40C0_0000 || rsp_flags !== 5'd0) begin
      errors++;
      $display("FAIL single_rsp got cyc=%0d id=%0d r=%h f=%b required 3 1 40c00000 00000",
               cyc, rsp_id, rsp_r, rsp_flags);
    end
    step();
  endtask

  task automatic test_rotation();
    int g_ids[$];
    int r_ids[$];
    int r_cyc[$];
    do_reset();
    req_valid = 4'b1111;
    rand_ops();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_ids.push_back(i);
      if (rsp_valid) begin
        r_ids.push_back(int'(rsp_id));
        r_cyc.push_back(k);
      end
      step();
      if (k == 7) req_valid = '0;
      else rand_ops();
    end
    checks++;
    if (g_ids.size() != 8 || r_ids.size() != 8) begin
      errors++;
      $display("FAIL rot_count grants=%0d rsps=%0d required 8 8", g_ids.size(), r_ids.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (g_ids[k] != k % 4 || r_ids[k] != k % 4) begin
          errors++;
          $display("FAIL rot_order idx=%0d grant=%0d rsp=%0d required %0d", k, g_ids[k], r_ids[k], k % 4);
        end
      end
      checks++;
      if (r_cyc[0] != 3 || r_cyc[7] != 10) begin
        errors++;
        $display("FAIL rot_b2b first=%0d last=%0d required 3 10", r_cyc[0], r_cyc[7]);
      end
    end
  endtask

  task automatic test_div_zero();
    bit seen;
    seen = 1'b0;
    req_a[64 +: 32] = 32'h3F80_0000;
    req_b[64 +: 32] = 32'h0000_0000;
    req_sel[2] = 1'b1;
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        checks++;
        if (rsp_r !== 32'h7F80_0000 || rsp_flags[3] !== 1'b1 || rsp_id !== 2'd2) begin
          errors++;
          $display("FAIL div_zero got r=%h f=%b id=%0d required 7f800000 dz=1 id=2", rsp_r, rsp_flags, rsp_id);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL div_zero_timeout got no response required one");
    end
    step();
  endtask

  task automatic test_run_drain();
    int  base;
    bit  bad;
    base = rsp_seen;
    bad = 1'b0;
    rand_ops();
    req_valid = 4'b0011;
    step();
    step();
    run = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || idle !== 1'b0) begin
      errors++;
      $display("FAIL run_off got ready=%b idle=%b required 0000 0", req_ready, idle);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      @(negedge clk);
      if (req_ready !== 4'b0000) bad = 1'b1;
    end
    checks++;
    if (bad || rsp_seen - base != 2 || idle !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL run_drain got stray=%b rsps=%0d idle=%b pending=%0d required 0 2 1 0",
               bad, rsp_seen - base, idle, exp_q.size());
    end
    step();
    req_valid = '0;
    run = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    int base;
    rand_ops();
    req_valid = 4'b0110;
    step();
    step();
    arst = 1'b0;
    #1;
    checks++;
    if ({req_ready, md_en, md_a, md_b, md_sel, rsp_valid, rsp_id, rsp_r, rsp_flags, idle} !==
        {4'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_values en=%b a=%h rv=%b idle=%b ready=%b required 0 0 0 1 0",
               md_en, md_a, rsp_valid, idle, req_ready);
    end
    exp_q.delete();
    base = rsp_seen;
    req_valid = '0;
    step();
    arst = 1'b1;
    for (int k = 0; k < 6; k++) step();
    checks++;
    if (rsp_seen != base) begin
      errors++;
      $display("FAIL reset_mid_discard got %0d responses required 0", rsp_seen - base);
    end
    req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_ptr got %b required 0001", req_ready);
    end
    step();
    req_valid = '0;
    for (int k = 0; k < 6; k++) step();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      rand_ops();
      req_valid = 4'($urandom_range(0, 15));
      run = ($urandom_range(0, 7) != 0);
      step();
    end
    req_valid = '0;
    run = 1'b1;
    for (int k = 0; k < 8; k++) step();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain pending=%0d idle=%b required 0 1", exp_q.size(), idle);
    end
    step();
  endtask

`ifdef MULDIV_SCHED_PERF_EN
  task automatic test_perf();
    do_reset();
    rand_ops();
    req_valid = 4'b0001;
    for (int k = 0; k < 65600; k++) step();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (perf_grants[15:0] !== 16'hFFFF || perf_grants[31:16] !== 16'h0 || perf_busy !== 16'hFFFF) begin
      errors++;
      $display("FAIL perf_sat got g0=%h g1=%h busy=%h required ffff 0000 ffff",
               perf_grants[15:0], perf_grants[31:16], perf_busy);
    end
    for (int k = 0; k < 6; k++) step();
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (perf_grants[15:0] !== 16'h0 || perf_busy !== 16'h0) begin
      errors++;
      $display("FAIL perf_clr got g0=%h busy=%h required 0000 0000", perf_grants[15:0], perf_busy);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_div_zero();
    test_run_drain();
    test_reset_mid();
    test_back_to_back();
`ifdef MULDIV_SCHED_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
